// File: rtl/engine_adder_tree.sv
// engine_adder_tree: reduces LANES signed lane inputs through a registered
// pairwise adder tree. Each tree sum is shifted, optionally negated, and
// accumulated over a multi-beat sequence that ends on a tagged last beat.
// The design has no backpressure and accepts one beat every cycle.
module engine_adder_tree #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned IN_W    = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned SAT_EN  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     in_valid,
  input  logic [LANES*IN_W-1:0]    in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic                     in_neg,
  input  logic                     in_last,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     out_valid,
  output logic                     ovf
);

  localparam int unsigned LVL    = $clog2(LANES);
  // Tree nodes are held at the final tree width. Each level still adds one
  // bit of headroom: level l only ever needs IN_W+l bits.
  localparam int unsigned TW     = IN_W + LVL;
  localparam int unsigned NODES  = 2 * LANES - 1;
  // Wide enough to hold the true shifted and negated term exactly.
  localparam int unsigned TERM_W = ACC_W + (1 << SHIFT_W) + 1;
  localparam int unsigned SUM_W  = TERM_W + 1;

  // Flat node storage. Level 0 holds the registered lanes at offset 0.
  // Level l starts at offset 2*LANES - 2*(LANES>>l). The root is the last node.
  function automatic int unsigned lvl_off(input int unsigned l);
    return 2 * LANES - 2 * (LANES >> l);
  endfunction

  logic signed [TW-1:0]   node_q [NODES];
  logic [LVL:0]           vld_q;
  logic [LVL:0]           neg_q;
  logic [LVL:0]           last_q;
  logic [SHIFT_W-1:0]     shf_q  [LVL+1];

  logic signed [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0]        acc_out_q;
  logic                    out_valid_q;
  logic                    ovf_q;

  logic signed [TW-1:0]    root;
  logic [TERM_W-1:0]       ext;
  logic [TERM_W-1:0]       shifted;
  logic [TERM_W-1:0]       term_w;
  logic [SUM_W-1:0]        sum_w;
  logic                    term_ovf;
  logic                    sum_ovf;
  logic [ACC_W-1:0]        acc_d;

  // Tree data path: register the sign-extended lanes, then add pairs level by level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned n = 0; n < NODES; n++) begin
        node_q[n] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < LANES; j++) begin
        node_q[j] <= TW'($signed(in_data[j*IN_W +: IN_W]));
      end
      for (int unsigned l = 1; l <= LVL; l++) begin
        for (int unsigned j = 0; j < (LANES >> l); j++) begin
          node_q[lvl_off(l) + j] <= node_q[lvl_off(l-1) + 2*j]
                                  + node_q[lvl_off(l-1) + 2*j + 1];
        end
      end
    end
  end

  // Sideband moves with the data. Only the valid bits are cleared by init,
  // and that alone is enough to drop every beat still in the tree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      neg_q  <= '0;
      last_q <= '0;
      for (int unsigned l = 0; l <= LVL; l++) begin
        shf_q[l] <= '0;
      end
    end else begin
      if (init) begin
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[LVL-1:0], in_valid};
      end
      neg_q    <= {neg_q[LVL-1:0], in_neg};
      last_q   <= {last_q[LVL-1:0], in_last};
      shf_q[0] <= in_shift;
      for (int unsigned l = 1; l <= LVL; l++) begin
        shf_q[l] <= shf_q[l-1];
      end
    end
  end

  assign root = node_q[NODES-1];

  // Shift, negate and add at full precision. Overflow of the term and
  // overflow of the sum are both detected from the high bits of the wide values.
  always_comb begin
    ext      = TERM_W'(root);
    shifted  = ext << shf_q[LVL];
    term_w   = neg_q[LVL] ? ('0 - shifted) : shifted;
    term_ovf = (|term_w[TERM_W-1:ACC_W-1]) && !(&term_w[TERM_W-1:ACC_W-1]);
    sum_w    = SUM_W'(acc_q) + SUM_W'($signed(term_w));
    sum_ovf  = (|sum_w[SUM_W-1:ACC_W-1]) && !(&sum_w[SUM_W-1:ACC_W-1]);
    acc_d    = sum_w[ACC_W-1:0];
    if ((SAT_EN != 0) && sum_ovf) begin
      acc_d = sum_w[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator and result registers. init overrides any beat arriving here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (init) begin
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (vld_q[LVL]) begin
        if (term_ovf || sum_ovf) begin
          ovf_q <= 1'b1;
        end
        if (last_q[LVL]) begin
          acc_out_q   <= acc_d;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end

  assign acc_out   = acc_out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_engine_adder_tree.sv
// Directed bench for engine_adder_tree. It drives two instances, one that
// wraps and one that saturates, from the same stimulus.
module tb_engine_adder_tree;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic        in_valid;
  logic [63:0] in_data;
  logic [2:0]  in_shift;
  logic        in_neg;
  logic        in_last;

  logic [23:0] acc_w, acc_s;
  logic        ov_w, ov_s;
  logic        of_w, of_s;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  engine_adder_tree #(.LANES(4), .IN_W(16), .ACC_W(24), .SHIFT_W(3), .SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_data(in_data),
    .in_shift(in_shift), .in_neg(in_neg), .in_last(in_last),
    .acc_out(acc_w), .out_valid(ov_w), .ovf(of_w));

  engine_adder_tree #(.LANES(4), .IN_W(16), .ACC_W(24), .SHIFT_W(3), .SAT_EN(1)) u_sat (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_data(in_data),
    .in_shift(in_shift), .in_neg(in_neg), .in_last(in_last),
    .acc_out(acc_s), .out_valid(ov_s), .ovf(of_s));

  // Count result pulses independently of the directed checks.
  always @(negedge clk) if (ov_w === 1'b1) pulses++;

  typedef struct {
    int          l0, l1, l2, l3;
    logic [2:0]  sh;
    logic        ng;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%06h want 0x%06h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c, input int d,
                       input logic [2:0] sh, input logic ng, input logic lst);
    in_valid = 1'b1;
    in_data  = {16'(d), 16'(c), 16'(b), 16'(a)};
    in_shift = sh;
    in_neg   = ng;
    in_last  = lst;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_neg   = 1'b0;
    in_shift = '0;
    in_data  = '0;
  endtask

  // Called once the last beat has been captured. The result must appear
  // exactly three edges later, as a one-cycle pulse.
  task automatic expect_pulse(input string nm, input logic [23:0] ew, input logic [23:0] es,
                              input logic eo);
    idle();
    step(); chk1({nm, " early1"}, ov_w, 1'b0);
    step(); chk1({nm, " early2"}, ov_w, 1'b0);
    step();
    chk1({nm, " vld_w"}, ov_w, 1'b1);
    chk1({nm, " vld_s"}, ov_s, 1'b1);
    chk ({nm, " acc_w"}, acc_w, ew);
    chk ({nm, " acc_s"}, acc_s, es);
    chk1({nm, " ovf_w"}, of_w, eo);
    chk1({nm, " ovf_s"}, of_s, eo);
    step(); chk1({nm, " pulse_end"}, ov_w, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 2, 3, 4, 3'd0, 1'b0, 24'h00000A};
    tbl[1] = '{-1, -1, -1, -1, 3'd0, 1'b0, 24'hFFFFFC};
    tbl[2] = '{1, 1, 1, 1, 3'd2, 1'b1, 24'hFFFFF0};
    tbl[3] = '{-32768, -32768, -32768, -32768, 3'd0, 1'b0, 24'hFE0000};
    tbl[4] = '{100, 0, 0, 0, 3'd7, 1'b0, 24'h003200};
    tbl[5] = '{5, -5, 7, -7, 3'd3, 1'b1, 24'h000000};
    tbl[6] = '{32767, 32767, 32767, 32767, 3'd5, 1'b1, 24'hC00080};

    rst  = 1'b1;
    init = 1'b0;
    idle();

    // Beats driven while reset is held must have no effect.
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 3, 4, 3'd0, 1'b0, 1'b1);
      step();
      chk ("rst acc", acc_w, 24'h0);
      chk1("rst vld", ov_w, 1'b0);
      chk1("rst ovf", of_s, 1'b0);
    end
    idle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("post-rst vld", ov_w, 1'b0);
    end

    // Single-beat sequences from the table.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3, tbl[i].sh, tbl[i].ng, 1'b1);
      step();
      expect_pulse($sformatf("tbl%0d", i), tbl[i].exp, tbl[i].exp, 1'b0);
    end

    // Two-beat signed sequence: 10 - 64.
    drive(1, 2, 3, 4, 3'd0, 1'b0, 1'b0); step();
    drive(1, 1, 1, 1, 3'd4, 1'b1, 1'b1); step();
    expect_pulse("twoslice", 24'hFFFFCA, 24'hFFFFCA, 1'b0);

    // Four back-to-back single-beat sequences.
    drive(5, 0, 0, 0, 3'd0, 1'b0, 1'b1);      step();
    drive(-3, 0, 0, 0, 3'd0, 1'b0, 1'b1);     step();
    drive(0, 0, 0, 0, 3'd0, 1'b0, 1'b1);      step();
    drive(25, 25, 25, 25, 3'd0, 1'b0, 1'b1);  step();
    idle();
    chk1("b2b0 vld", ov_w, 1'b1); chk("b2b0 acc", acc_w, 24'h000005); step();
    chk1("b2b1 vld", ov_w, 1'b1); chk("b2b1 acc", acc_w, 24'hFFFFFD); step();
    chk1("b2b2 vld", ov_w, 1'b1); chk("b2b2 acc", acc_w, 24'h000000); step();
    chk1("b2b3 vld", ov_w, 1'b1); chk("b2b3 acc", acc_s, 24'h000064); step();
    chk1("b2b end", ov_w, 1'b0);

    // init one cycle after a last beat, together with a beat of its own.
    drive(3, 3, 3, 3, 3'd0, 1'b0, 1'b1); step();
    drive(9, 9, 9, 9, 3'd0, 1'b0, 1'b1);
    init = 1'b1;
    step();
    init = 1'b0;
    idle();
    chk("init acc", acc_w, 24'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("init vld", ov_w, 1'b0);
      chk ("init acc hold", acc_s, 24'h0);
    end
    drive(2, 2, 2, 2, 3'd0, 1'b0, 1'b1); step();
    expect_pulse("after-init", 24'h000008, 24'h000008, 1'b0);

    // Term overflow in the positive direction.
    drive(32767, 32767, 32767, 32767, 3'd7, 1'b0, 1'b1); step();
    expect_pulse("ovf-pos", 24'hFFFE00, 24'h7FFFFF, 1'b1);
    // ovf remains set through a normal sequence.
    drive(1, 2, 3, 4, 3'd0, 1'b0, 1'b1); step();
    expect_pulse("ovf-sticky", 24'h00000A, 24'h00000A, 1'b1);
    // Term overflow in the negative direction: -2^24.
    drive(-32768, -32768, -32768, -32768, 3'd7, 1'b0, 1'b1); step();
    expect_pulse("ovf-neg", 24'h000000, 24'h800000, 1'b1);
    // init clears ovf.
    init = 1'b1; step(); init = 1'b0;
    chk1("init ovf_w", of_w, 1'b0);
    chk1("init ovf_s", of_s, 1'b0);
    // Both terms fit, but their sum overflows: 8388352 + 262136.
    drive(32767, 32767, 32767, 32767, 3'd6, 1'b0, 1'b0); step();
    drive(32767, 32767, 0, 0, 3'd2, 1'b0, 1'b1); step();
    expect_pulse("ovf-sum", 24'h83FEF8, 24'h7FFFFF, 1'b1);

    step();
    checks++;
    if (pulses != 17) begin
      errors++;
      $display("FAIL pulse count: got %0d want 17", pulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/engine_adder_tree.md
Name: engine_adder_tree

Overview:
Parametrised successor to the fixed 4-input nibble accumulator in the multiply engine. It reduces LANES signed partial products through a fully registered adder tree, then applies a per-beat left shift and optional negation. The result is accumulated over a multi-beat sequence that ends on a tagged last beat. Sits between the partial-product generators and the result writeback, with no backpressure: a new beat can be accepted every cycle.

Parameters:
LANES, 4, number of input lanes; power of 2, range 2..16
IN_W, 16, width of each signed lane input
ACC_W, 24, accumulator and result width, signed; must be at least IN_W + log2(LANES)
SHIFT_W, 3, width of the shift-amount field
SAT_EN, 0, 1 = saturate on accumulator overflow; 0 = wrap modulo 2^ACC_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
init  in  1  synchronous clear of pipeline and accumulator
in_valid  in  1  beat present this cycle
in_data  in  LANES*IN_W  lane i occupies bits [i*IN_W +: IN_W]; two's complement
in_shift  in  SHIFT_W  left-shift amount applied to this beat's lane sum
in_neg  in  1  subtract this beat's shifted sum instead of adding it
in_last  in  1  final beat of the current accumulation
acc_out  out  ACC_W  result of the last completed accumulation, held until replaced
out_valid  out  1  one-cycle pulse when acc_out updates
ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst=1, asynchronous): all outputs go to 0 (acc_out, out_valid, ovf). The running accumulator, all tree stage registers and the valid/shift/neg/last sideband go to 0.
- Tree:
  - log2(LANES) registered levels; each level adds pairs and widens by 1 bit with sign extension.
  - in_shift, in_neg and in_last travel alongside the data in matching valid-tagged registers.
- Shift/negate stage (combinational, in front of the accumulator):
  - term = sign-extend(tree sum) to ACC_W, then << in_shift.
  - If in_neg=1, term = two's-complement negation of term.
  - Bits shifted above ACC_W are lost. If the true term does not fit in ACC_W, ovf is set.
- Accumulate (registered):
  - On a valid beat: acc_next = acc + term.
  - If in_last=0: acc <= acc_next.
  - If in_last=1: acc_out <= acc_next, out_valid <= 1 for one cycle, and acc <= 0, so the next beat starts a fresh sum with no bubble.
- Latency: L = log2(LANES) + 1. A last beat sampled at edge k produces out_valid=1 during the cycle after edge k+L. Full throughput: one beat per cycle, indefinitely.
- Overflow:
  - Signed overflow of acc + term sets ovf.
  - SAT_EN=1: acc_next clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - SAT_EN=0: acc_next wraps.
  - ovf stays set until rst or init.
- in_valid=0 cycles: bubbles propagate; accumulator and acc_out are unchanged.
- init=1 (synchronous):
  - Clears acc, all stage valids and ovf; acc_out is cleared to 0.
  - In-flight beats are dropped. A beat presented in the same cycle as init is ignored.
  - A last beat reaching the accumulator in the init cycle produces no out_valid. init has priority over every other event.
- rst asserted mid-sequence: everything is discarded immediately. The first beat after deassertion starts a new sum.
- A single beat with in_last=1 is a complete 1-beat accumulation.

Test Plan:
- Reset: hold rst=1 while driving beats -> acc_out=0, out_valid=0, ovf=0. After release, no spurious out_valid.
- Single beat: LANES=4, in_data={1,2,3,4}, shift 0, neg 0, last 1 -> out_valid exactly 3 cycles later, acc_out=10 (0x00000A).
- Signed two-slice: beat1 {1,2,3,4}, shift 0; next cycle beat2 {1,1,1,1}, shift 4, neg 1, last -> single out_valid, acc_out=10-64=-54 (0xFFFFCA), ovf=0.
- Back-to-back: 4 consecutive 1-beat sequences with sums 5, -3, 0, 100 -> 4 consecutive out_valid pulses with acc_out 5, 0xFFFFFD, 0, 100; no carry-over between sequences.
- init mid-flight: beats with last issued, init pulsed 1 cycle later -> no out_valid, acc_out=0. The next 1-beat {2,2,2,2} produces acc_out=8.
- Overflow: {32767 x4}, shift 7, last (term = 16776704):
  - SAT_EN=1 -> acc_out=0x7FFFFF, ovf=1.
  - SAT_EN=0 -> acc_out=0xFFFE00, ovf=1.
  - ovf stays 1 across the following sequence until init.
